fifo_1h_stat: RTL and testbench
===============================

// Module: fifo_1h_stat
// PURPOSE
//  Parametrised single-clock FIFO: one-hot rotating read/write pointers, flop-array storage.
//  Adds correct wrap-around, true full/empty, occupancy count, almost-full, flush,
//  sticky over/underflow errors and a selectable read mode (registered or show-ahead).
//  General-purpose buffering between pipeline stages in the interview-question RTL set.
// PARAMETERS
//  W        32    data width, >=1
//  N        16    depth (entries), >=2
//  AFULL    14    almost_full_r asserts when count >= AFULL; 1..N
//  RD_MODE  0     0 = registered pop data, 1 = show-ahead (head visible combinationally)
// PORTS
//  clk               in   1              clock
//  rst               in   1              synchronous reset, active high
//  flush             in   1              discard contents, clear errors
//  push              in   1              write request
//  push_data         in   W              write data
//  pop               in   1              read request
//  pop_data_valid_r  out  1              pop_data valid (see BEHAVIOUR)
//  pop_data          out  W              read data
//  empty_r           out  1              FIFO empty
//  full_r            out  1              FIFO full
//  almost_full_r     out  1              count >= AFULL
//  count_r           out  $clog2(N+1)    occupancy, 0..N
//  overflow_r        out  1              sticky: push while full (and no pop)
//  underflow_r       out  1              sticky: pop while empty
// BEHAVIOUR
//  Clock clk; rst synchronous, active high, highest priority.
//  - Reset: wr/rd ptr = 'b1, count_r=0, empty_r=1, full_r=0, almost_full_r=0,
//    overflow_r=0, underflow_r=0, pop_data_valid_r=0; pop_data=0 in RD_MODE 0.
//  - Pointers rotate left; bit N-1 wraps to bit 0 (never shift out to zero).
//  - pop_acc = pop & !empty_r. push_acc = push & (!full_r | pop_acc).
//  - push when full with simultaneous accepted pop: accepted; head read before overwrite.
//  - push & pop when empty: push accepted, pop rejected (underflow); no fall-through.
//  - Rejected push: storage/pointers untouched, overflow_r <= 1.
//  - Rejected pop: underflow_r <= 1.
//  - count_nxt = count + push_acc - pop_acc; empty/full/almost_full registered from count_nxt.
//  - flush (not rst): ptrs to 'b1, count 0, empty 1, errors cleared.
//    Same-cycle push/pop ignored, no error raised. pop_data_valid_r <= 0.
//  - Status outputs update one cycle after the causing push/pop/flush.
//  - RD_MODE 0: pop accepted at cycle t -> cycle t+1: pop_data_valid_r=1, pop_data=entry
//    popped. Otherwise pop_data_valid_r=0, pop_data holds last value.
//  - RD_MODE 1: pop_data = mem[rd_ptr] (AND-OR mux). pop_data_valid_r = !empty_r.
//    pop consumes the displayed entry.
//  - Errors clear only on rst/flush. Storage not reset.
// STRUCTURE
//  - fifo_pkg: rd_mode_t enum (RD_REG=0, RD_SHOW_AHEAD=1); helper CNT_W(N)=$clog2(N+1).
//  - Sub-module fifo_1h_ptr #(N): one-hot rotating pointer with en/flush, instanced twice (wr, rd).
//  - Top: count/flag logic, write-enable decode, one-hot AND-OR read mux, RD_MODE generate.
// TESTING
//  1. Reset then push 16 (N=16) -> full_r=1 and count_r=16 after last push;
//     almost_full_r=1 from the 14th push.
//  2. Push 17th while full -> overflow_r=1. Pop 16 -> data 0..15 in order, empty_r=1, no loss.
//  3. Wrap: 40 pushes/pops interleaved at occupancy 3 -> in-order data, ptrs stay one-hot.
//  4. Full + push&pop same cycle -> count_r stays 16; popped=old head, new data at tail.
//  5. Empty + pop -> underflow_r=1, pop_data_valid_r=0. Flush with push=1 at count 5 ->
//     count_r=0, empty_r=1, errors cleared.
//  6. RD_MODE=1: push A,B -> pop_data=A while empty_r=0. Pop -> next cycle pop_data=B.
//     rst mid-traffic -> all outputs at reset values.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the one-hot pointer FIFO.
package fifo_pkg;

  // Read-side presentation: registered pop data or head shown combinationally.
  typedef enum logic {
    RD_REG        = 1'b0,
    RD_SHOW_AHEAD = 1'b1
  } rd_mode_t;

  // Width of an occupancy counter that must represent 0..n inclusive.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_1h_ptr.sv
// One-hot rotating pointer: advances left on en_i, bit N-1 wraps to bit 0.
module fifo_1h_ptr #(
  parameter int unsigned N = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         flush_i,
  output logic [N-1:0] ptr_o
);

  localparam logic [N-1:0] PTR_INIT = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] ptr_q;
  logic [N-1:0] ptr_d;

  // Next pointer: flush returns to slot 0, otherwise rotate when enabled.
  always_comb begin
    ptr_d = ptr_q;
    if (flush_i) begin
      ptr_d = PTR_INIT;
    end else if (en_i) begin
      ptr_d = {ptr_q[N-2:0], ptr_q[N-1]};
    end
  end

  // Pointer register with synchronous reset to slot 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= PTR_INIT;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_1h_stat.sv
// Single-clock FIFO with one-hot pointers, flop storage, occupancy/status flags,
// sticky over/underflow errors, flush, and registered or show-ahead read data.
module fifo_1h_stat
  import fifo_pkg::*;
#(
  parameter int unsigned W       = 32,
  parameter int unsigned N       = 16,
  parameter int unsigned AFULL   = 14,
  parameter rd_mode_t    RD_MODE = RD_REG
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic [W-1:0]        push_data,
  input  logic                pop,
  output logic                pop_data_valid_r,
  output logic [W-1:0]        pop_data,
  output logic                empty_r,
  output logic                full_r,
  output logic                almost_full_r,
  output logic [cnt_w(N)-1:0] count_r,
  output logic                overflow_r,
  output logic                underflow_r
);

  localparam int unsigned CW = cnt_w(N);

  logic          pop_acc;
  logic          push_acc;
  logic [N-1:0]  wr_ptr;
  logic [N-1:0]  rd_ptr;
  logic [W-1:0]  mem [N];
  logic [W-1:0]  head;

  logic [CW-1:0] count_q, count_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  // Acceptance: a pop frees the slot a full-FIFO push needs; flush masks both.
  always_comb begin
    pop_acc  = pop & ~empty_q & ~flush;
    push_acc = push & (~full_q | pop_acc) & ~flush;
  end

  fifo_1h_ptr #(.N(N)) u_wr_ptr (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (push_acc),
    .flush_i (flush),
    .ptr_o   (wr_ptr)
  );

  fifo_1h_ptr #(.N(N)) u_rd_ptr (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (pop_acc),
    .flush_i (flush),
    .ptr_o   (rd_ptr)
  );

  // Next occupancy, flags derived from the next count, sticky error capture.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (flush) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      count_d = count_q + CW'(push_acc) - CW'(pop_acc);
      if (push & ~push_acc) ovf_d = 1'b1;
      if (pop & empty_q)    unf_d = 1'b1;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(N));
    afull_d = (count_d >= CW'(AFULL));
  end

  // Status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage write: the one-hot write pointer is the per-entry write enable.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < N; i++) begin
      if (push_acc && wr_ptr[i]) mem[i] <= push_data;
    end
  end

  // Head-of-queue AND-OR mux selected by the one-hot read pointer.
  always_comb begin
    head = '0;
    for (int unsigned i = 0; i < N; i++) begin
      head = head | (mem[i] & {W{rd_ptr[i]}});
    end
  end

  generate
    if (RD_MODE == RD_REG) begin : g_rd_reg
      logic [W-1:0] data_q;
      logic         valid_q;

      // Capture the head on an accepted pop; data holds otherwise.
      always_ff @(posedge clk) begin
        if (rst) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= pop_acc;
          if (pop_acc) data_q <= head;
        end
      end

      assign pop_data         = data_q;
      assign pop_data_valid_r = valid_q;
    end else begin : g_rd_show_ahead
      assign pop_data         = head;
      assign pop_data_valid_r = ~empty_q;
    end
  endgenerate

  assign empty_r       = empty_q;
  assign full_r        = full_q;
  assign almost_full_r = afull_q;
  assign count_r       = count_q;
  assign overflow_r    = ovf_q;
  assign underflow_r   = unf_q;

endmodule

// File: tb/tb_fifo_1h_stat.sv
// Bench for fifo_1h_stat: one stimulus stream drives a registered-read and a
// show-ahead instance; a queue-based reference model supplies all expectations.
module tb_fifo_1h_stat;
  import fifo_pkg::*;

  localparam int unsigned W     = 32;
  localparam int unsigned N     = 16;
  localparam int unsigned AFULL = 14;

  logic          clk = 1'b0;
  logic          rst, flush, push, pop;
  logic [W-1:0]  push_data;

  logic          r_valid, r_empty, r_full, r_afull, r_ovf, r_unf;
  logic [W-1:0]  r_data;
  logic [4:0]    r_count;
  logic          s_valid, s_empty, s_full, s_afull, s_ovf, s_unf;
  logic [W-1:0]  s_data;
  logic [4:0]    s_count;

  always #5 clk = ~clk;

  fifo_1h_stat #(.W(W), .N(N), .AFULL(AFULL), .RD_MODE(RD_REG)) u_reg (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data), .pop(pop),
    .pop_data_valid_r(r_valid), .pop_data(r_data), .empty_r(r_empty), .full_r(r_full),
    .almost_full_r(r_afull), .count_r(r_count), .overflow_r(r_ovf), .underflow_r(r_unf)
  );

  fifo_1h_stat #(.W(W), .N(N), .AFULL(AFULL), .RD_MODE(RD_SHOW_AHEAD)) u_sa (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .push_data(push_data), .pop(pop),
    .pop_data_valid_r(s_valid), .pop_data(s_data), .empty_r(s_empty), .full_r(s_full),
    .almost_full_r(s_afull), .count_r(s_count), .overflow_r(s_ovf), .underflow_r(s_unf)
  );

  // Reference model state
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  bit           m_ovf, m_unf;
  logic [W-1:0] m_last;
  bit           m_rst_seen;
  bit           chk_en = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO rules applied to the state before the edge.
  task automatic model_step(input bit ps, input logic [W-1:0] d, input bit pp, input bit fl, input bit rs);
    bit pa, ua;
    if (rs) begin
      mq.delete(); exp_q.delete();
      m_ovf = 0; m_unf = 0; m_rst_seen = 1;
    end else if (fl) begin
      mq.delete();
      m_ovf = 0; m_unf = 0;
    end else begin
      pa = pp && (mq.size() > 0);
      ua = ps && ((mq.size() < N) || pa);
      if (ps && !ua) m_ovf = 1;
      if (pp && mq.size() == 0) m_unf = 1;
      if (pa) exp_q.push_back(mq.pop_front());
      if (ua) mq.push_back(d);
    end
  endtask

  task automatic cyc(input bit ps, input logic [W-1:0] d, input bit pp, input bit fl, input bit rs);
    @(negedge clk);
    #1;
    push = ps; push_data = d; pop = pp; flush = fl; rst = rs;
    @(posedge clk);
    model_step(ps, d, pp, fl, rs);
  endtask

  // Monitor: status of both instances against the model, read data from the scoreboard.
  always @(negedge clk) begin
    if (chk_en) begin
      if (m_rst_seen) begin
        m_last = '0;
        m_rst_seen = 0;
      end
      chk("count", 64'(r_count), 64'(mq.size()));
      chk("empty", 64'(r_empty), 64'(mq.size() == 0));
      chk("full", 64'(r_full), 64'(mq.size() == N));
      chk("almost_full", 64'(r_afull), 64'(mq.size() >= AFULL));
      chk("overflow", 64'(r_ovf), 64'(m_ovf));
      chk("underflow", 64'(r_unf), 64'(m_unf));
      chk("sa_count", 64'(s_count), 64'(mq.size()));
      chk("sa_flags", 64'({s_empty, s_full, s_afull, s_ovf, s_unf}),
          64'({mq.size() == 0, mq.size() == N, mq.size() >= AFULL, m_ovf, m_unf}));
      chk("wr_ptr_onehot", 64'($onehot(u_reg.u_wr_ptr.ptr_o)), 64'd1);
      chk("rd_ptr_onehot", 64'($onehot(u_reg.u_rd_ptr.ptr_o)), 64'd1);
      if (r_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 64'(r_valid), 64'd0);
        end else begin
          m_last = exp_q.pop_front();
          chk("pop_data", 64'(r_data), 64'(m_last));
        end
      end else begin
        if (exp_q.size() != 0) begin
          chk("missing_valid", 64'(r_valid), 64'd1);
          void'(exp_q.pop_front());
        end
        chk("pop_data_hold", 64'(r_data), 64'(m_last));
      end
      chk("sa_valid", 64'(s_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) chk("sa_head", 64'(s_data), 64'(mq[0]));
    end
  end

  initial begin
    int unsigned pp_push, pp_pop;
    rst = 1; flush = 0; push = 0; pop = 0; push_data = '0;
    m_ovf = 0; m_unf = 0; m_last = '0; m_rst_seen = 0;
    cyc(0, '0, 0, 0, 1);
    chk_en = 1;
    cyc(0, '0, 0, 0, 1);
    // fill to full, then overflow attempt
    for (int i = 0; i < 16; i++) cyc(1, W'(i), 0, 0, 0);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 0);
    // drain in order, then underflow and push+pop on empty
    for (int i = 0; i < 16; i++) cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 1, 0, 0);
    cyc(1, 32'hA5A5_0001, 1, 0, 0);
    cyc(0, '0, 0, 1, 0);
    // refill, push+pop while full
    for (int i = 0; i < 16; i++) cyc(1, $urandom, 0, 0, 0);
    cyc(1, 32'h1111_2222, 1, 0, 0);
    cyc(1, 32'h3333_4444, 1, 0, 0);
    for (int i = 0; i < 16; i++) cyc(0, '0, 1, 0, 0);
    // flush with push at count 5 after an error
    cyc(0, '0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0, 0);
    cyc(1, 32'h5555_6666, 1, 1, 0);
    // wrap at occupancy 3
    for (int i = 0; i < 3; i++) cyc(1, $urandom, 0, 0, 0);
    for (int i = 0; i < 40; i++) cyc(1, $urandom, 1, 0, 0);
    // show-ahead: push A,B then pop
    cyc(0, '0, 0, 1, 0);
    cyc(1, 32'h0000_000A, 0, 0, 0);
    cyc(1, 32'h0000_000B, 0, 0, 0);
    cyc(0, '0, 1, 0, 0);
    // randomized traffic with varying push/pop bias, rare flush and reset
    for (int blk = 0; blk < 6; blk++) begin
      pp_push = 20 + 12 * blk;
      pp_pop  = 80 - 12 * blk;
      for (int i = 0; i < 120; i++) begin
        cyc($urandom_range(99) < pp_push, $urandom, $urandom_range(99) < pp_pop,
            $urandom_range(59) == 0, $urandom_range(149) == 0);
      end
    end
    for (int i = 0; i < 18; i++) cyc(0, '0, 1, 0, 0);
    cyc(0, '0, 0, 0, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
